// File: rtl/fas_serial_alu.sv
// Bit-serial add/subtract unit: one full adder/subtractor cell, LSB first, start/done handshake.
// Optional macro FAS_SERIAL_OVF_EN enables the signed-overflow flag; otherwise ovf is tied to 0.
module fas_serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             a_ns,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             add_q;
  logic             c_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;

  logic             a_bit;
  logic             b_bit;
  logic             sum_d;
  logic             carry_d;

  // The single adder/subtractor slice; c_q is carry for add and borrow for subtract.
  assign a_bit   = a_q[0];
  assign b_bit   = b_q[0];
  assign sum_d   = a_bit ^ b_bit ^ c_q;
  assign carry_d = add_q ? ((a_bit & b_bit) | (c_q & (a_bit ^ b_bit)))
                         : ((~a_bit & b_bit) | (c_q & ~(a_bit ^ b_bit)));

`ifdef FAS_SERIAL_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // Only meaningful on the MSB step, where a_bit/b_bit/sum_d are the sign bits.
  assign ovf_d = add_q ? (c_q ^ carry_d)
                       : ((a_bit != b_bit) & (sum_d != a_bit));
  assign ovf   = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      add_q    <= 1'b0;
      c_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
`ifdef FAS_SERIAL_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            add_q   <= a_ns;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end

        SHIFT: begin
          result_q <= {sum_d, result_q[WIDTH-1:1]};
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          c_q      <= carry_d;
          if (cnt_q == LAST_BIT) begin
            cout_q  <= carry_d;
`ifdef FAS_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_fas_serial_alu.sv
// Self-checking bench for fas_serial_alu (WIDTH=8): directed cases plus random operations
// compared with an arithmetic reference model; honours FAS_SERIAL_OVF_EN like the design.
module tb_fas_serial_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         a_ns;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int total  = 0;
  int passed = 0;

  fas_serial_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .a_ns   (a_ns),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic on unsigned and two's-complement views.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic add,
                       output logic [W-1:0] r, output logic c, output logic v);
    longint ua, ub, sa, sb, ures, sres;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - (longint'(1) << W) : ua;
    sb = b[W-1] ? ub - (longint'(1) << W) : ub;
    if (add) begin
      ures = ua + ub;
      sres = sa + sb;
      c    = (ures >= (longint'(1) << W));
    end else begin
      ures = ua - ub;
      sres = sa - sb;
      c    = (ua < ub);
    end
    r = W'(ures);
`ifdef FAS_SERIAL_OVF_EN
    v = (sres > ((longint'(1) << (W - 1)) - 1)) || (sres < -(longint'(1) << (W - 1)));
`else
    v = 1'b0;
`endif
  endtask

  // Steps clocks until done, bounded; reports edges taken and whether busy stayed high.
  task automatic wait_done(input bit scramble, output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 3 * W) begin
      if (!busy) busy_ok = 1'b0;
      if (scramble) begin
        a_in = W'($urandom);
        b_in = W'($urandom);
        a_ns = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic add);
    logic [W-1:0] er;
    logic ec, ev;
    int n;
    bit busy_ok;
    model(a, b, add, er, ec, ev);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    a_ns  = add;
    @(posedge clk); #1;
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    a_ns  = 1'($urandom);
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    wait_done(1'b0, n, busy_ok);
    check({tag, "_latency"}, 32'(n), 32'(W));
    check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(ev));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_result_hold"}, 32'(result), 32'(er));
  endtask

  initial begin
    logic [W-1:0] a0, b0, a1, b1, er;
    logic         ns1, ec, ev;
    int           n, k;
    bit           busy_ok;

    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    a_ns  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);

    run_op("add_1_0", 8'h01, 8'h00, 1'b1);
    run_op("add_ff_1", 8'hFF, 8'h01, 1'b1);
    run_op("add_7f_1", 8'h7F, 8'h01, 1'b1);
    run_op("sub_0_1", 8'h00, 8'h01, 1'b0);
    run_op("sub_5_3", 8'h05, 8'h03, 1'b0);
    run_op("sub_80_1", 8'h80, 8'h01, 1'b0);
    run_op("sub_eq", 8'hA5, 8'hA5, 1'b0);

    // start held high throughout, operands scrambled every cycle.
    a0 = W'($urandom);
    b0 = W'($urandom);
    a_in  = a0;
    b_in  = b0;
    a_ns  = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    check("ovl_busy_rise", 32'(busy), 32'd1);
    wait_done(1'b1, n, busy_ok);
    model(a0, b0, 1'b1, er, ec, ev);
    check("ovl_latency", 32'(n), 32'(W));
    check("ovl_busy_held", 32'(busy_ok), 32'd1);
    check("ovl_result", 32'(result), 32'(er));
    check("ovl_cout", 32'(cout), 32'(ec));
    k = 0;
    a1 = '0;
    b1 = '0;
    ns1 = 1'b0;
    while (k < 4) begin
      a1  = a_in;
      b1  = b_in;
      ns1 = a_ns;
      @(posedge clk); #1;
      k++;
      if (busy) break;
      a_in = W'($urandom);
      b_in = W'($urandom);
      a_ns = 1'($urandom);
    end
    check("ovl_reaccept_within_2", 32'(busy && k <= 2), 32'd1);
    wait_done(1'b1, n, busy_ok);
    start = 1'b0;
    model(a1, b1, ns1, er, ec, ev);
    check("ovl2_latency", 32'(n), 32'(W));
    check("ovl2_result", 32'(result), 32'(er));
    check("ovl2_cout", 32'(cout), 32'(ec));
    check("ovl2_ovf", 32'(ovf), 32'(ev));
    @(posedge clk); #1;

    // Reset during the 4th SHIFT cycle.
    start = 1'b1;
    a_in  = 8'hFF;
    b_in  = 8'hFF;
    a_ns  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    k = 0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (done) k++;
    end
    check("midrst_no_done", 32'(k), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_idle_after", 32'(busy), 32'd0);
    run_op("post_rst_add", 8'h10, 8'h20, 1'b1);

    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rand%0d", i), W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
